// File: rtl/btn_debounce_pkg.sv
// Shared constants and width helper for the btn_debounce block.
package btn_debounce_pkg;

    localparam int unsigned DBC_CYC_DEF = 851968;
    localparam int unsigned CH_MAX      = 32;

    // Ceiling log2: number of bits needed to hold values 0..value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned w;
        v = (value > 0) ? value - 1 : 0;
        w = 0;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return w;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned dbc);
        return (clog2(dbc) < 1) ? 1 : clog2(dbc);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchronizer, stability counter, level and edge pulses.
module debounce_ch
    import btn_debounce_pkg::*;
#(
    parameter int unsigned DBC_CYC = DBC_CYC_DEF,
    parameter logic        RST_LVL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned CW = cnt_width(DBC_CYC);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_lvl;
    logic          r_rise;
    logic          r_fall;
    logic          w_diff;
    logic          w_done;

    assign w_diff = r_sync[1] ^ r_lvl;
    assign w_done = (r_cnt == CW'(DBC_CYC - 1));

    // Sync flops reset to the same value as the level so release never looks like a change.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= {2{RST_LVL}};
            r_cnt  <= '0;
            r_lvl  <= RST_LVL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_pin};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_cnt  <= '0;
                r_lvl  <= ~r_lvl;
                r_rise <= ~r_lvl;
                r_fall <= r_lvl;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_lvl  = r_lvl;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button/switch debouncer with sticky event flags.
// Optional interrupt output enabled by defining BTN_DEBOUNCE_IRQ_EN.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int unsigned    CH      = 4,
    parameter int unsigned    DBC_CYC = DBC_CYC_DEF,
    parameter logic [CH-1:0]  RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] pin_i,
    output logic [CH-1:0] lvl_o,
    output logic [CH-1:0] rise_o,
    output logic [CH-1:0] fall_o,
    output logic [CH-1:0] evt_o,
    input  logic [CH-1:0] evt_clr
`ifdef BTN_DEBOUNCE_IRQ_EN
    ,
    input  logic [CH-1:0] irq_mask,
    output logic          irq_o
`endif
);

    logic [CH-1:0] w_rise;
    logic [CH-1:0] w_fall;
    logic [CH-1:0] r_evt;

    for (genvar g = 0; g < int'(CH); g++) begin : g_ch
        debounce_ch #(
            .DBC_CYC (DBC_CYC),
            .RST_LVL (RST_VAL[g])
        ) u_ch (
            .i_clk  (clk),
            .i_rst  (rst),
            .i_pin  (pin_i[g]),
            .o_lvl  (lvl_o[g]),
            .o_rise (w_rise[g]),
            .o_fall (w_fall[g])
        );
    end

    // New edges are ORed in after the clear, so a coincident set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_evt <= '0;
        end else begin
            r_evt <= (r_evt & ~evt_clr) | w_rise | w_fall;
        end
    end

    assign rise_o = w_rise;
    assign fall_o = w_fall;
    assign evt_o  = r_evt;

`ifdef BTN_DEBOUNCE_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_evt & irq_mask);
        end
    end

    assign irq_o = r_irq;
`endif

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter CH, default 4, meaning number of independent input channels (1..32).
REQ-002 SHALL have parameter DBC_CYC, default 851968, meaning the consecutive stable clk cycles required to accept a new level (10 ms at 85.1968 MHz; legal range 1..2^24).
REQ-003 SHALL have parameter RST_VAL, default all-zero [CH-1:0], meaning the per-channel level assumed at reset.
REQ-004 SHALL have port clk, input, 1, system clock; the block uses one clock only.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port pin_i, input, CH, asynchronous raw inputs (buttons, switches, rtc_irq_n).
REQ-007 SHALL have port lvl_o, output, CH, debounced level.
REQ-008 SHALL have port rise_o, output, CH, one-cycle pulse on an accepted 0->1 change.
REQ-009 SHALL have port fall_o, output, CH, one-cycle pulse on an accepted 1->0 change.
REQ-010 SHALL have port evt_o, output, CH, sticky per-channel event flags.
REQ-011 SHALL have port evt_clr, input, CH, write-one-to-clear for evt_o.

Function
REQ-012 Each pin_i bit SHALL pass through a 2-flop synchronizer before any use; no combinational path from pin_i to any output.
REQ-013 Each channel SHALL hold a counter of width clog2(DBC_CYC) (minimum 1 bit) that increments every cycle the synchronized input differs from lvl_o.
REQ-014 The counter SHALL clear to 0 in any cycle where the synchronized input equals lvl_o, so any glitch shorter than DBC_CYC cycles is rejected.
REQ-015 When the counter equals DBC_CYC-1 and the synchronized input still differs from lvl_o, then on the next edge:
  - lvl_o SHALL toggle,
  - the counter SHALL clear,
  - exactly one of rise_o/fall_o SHALL pulse high for one cycle, in the same cycle lvl_o changes.
REQ-016 Latency SHALL be exactly 2+DBC_CYC clk cycles from the first clk edge sampling a new pin_i level to the lvl_o change.
REQ-017 The counter SHALL never exceed DBC_CYC-1 and SHALL never wrap.
REQ-018 evt_o[i] SHALL set in the cycle after rise_o[i] or fall_o[i] and SHALL hold until cleared.
REQ-019 evt_clr[i] SHALL clear evt_o[i] on the next edge; if set and clear coincide, set SHALL win.
REQ-020 Channels SHALL be fully independent; simultaneous accepted changes on several channels SHALL all be reported in the same cycle.
REQ-021 With DBC_CYC=1, lvl_o SHALL follow the synchronized input with one extra cycle of delay.

Reset
REQ-022 While rst is high, at every clk edge:
  - synchronizer flops and lvl_o SHALL load RST_VAL,
  - counters SHALL load 0,
  - rise_o, fall_o and evt_o SHALL load 0.
REQ-023 Asserting rst mid-count SHALL discard the partial count; no edge pulse SHALL be generated by reset itself or on the cycle rst deasserts.

Configuration
REQ-024 With macro BTN_DEBOUNCE_IRQ_EN defined, the block SHALL add two ports:
  - irq_mask, input, CH,
  - irq_o, output, 1, registered, equal to |(evt_o & irq_mask) delayed by one cycle, reset value 0.
REQ-025 Without BTN_DEBOUNCE_IRQ_EN, irq_mask and irq_o SHALL be absent, with no other behavioural change.

Structure
REQ-026 Package btn_debounce_pkg SHALL hold:
  - the clog2 helper function,
  - the default constants DBC_CYC_DEF=851968 and CH_MAX=32.
REQ-027 Per-channel logic (synchronizer, counter, lvl, rise/fall) SHALL live in sub-module debounce_ch, instantiated CH times via generate; evt and irq logic stays in btn_debounce.

Verification (CH=4, DBC_CYC=8, RST_VAL=0)
REQ-028 Reset release, pin_i=0 -> lvl_o=0, rise_o=fall_o=evt_o=0 on every cycle for 20 cycles.
REQ-029 pin_i[0] 0->1 held -> lvl_o[0]=1 exactly 10 cycles after the first sampling edge; rise_o[0] high 1 cycle; evt_o[0]=1 one cycle later.
REQ-030 pin_i[1] high for 7 cycles then low -> lvl_o[1], rise_o[1] and evt_o[1] stay 0.
REQ-031 evt_o=4'b0001, then evt_clr[0] in the same cycle as a new fall_o[0] -> evt_o[0] remains 1; evt_clr[0] alone the next cycle -> evt_o[0]=0.
REQ-032 pin_i=4'b1111 at once -> rise_o=4'b1111 in a single cycle; rst pulsed at count 5 -> no pulses, lvl_o=0, re-count from 0 after release.
REQ-033 With BTN_DEBOUNCE_IRQ_EN, irq_mask=4'b0010 and an event on channel 0 only -> irq_o=0; an event on channel 1 -> irq_o=1 one cycle after evt_o[1] sets.
